stim_source: RTL and testbench
==============================

Name: stim_source

Overview:
- Synthesizable pseudo-random stimulus transmitter. It is the sending end of the valid-qualified data path that error_monitor checks.
- Produces a bounded sequence of DATAWIDTH-bit vectors from a 32-bit Galois LFSR, using a valid/ready handshake.
- Drives DUT inputs and behavioural-model inputs from one source. Benches and FPGA self-test wrappers get repeatable vectors without $random.

Parameters:
- DATAWIDTH, 16, output vector width; legal range 1..32.
- SEED, 32'h00000001, LFSR load value; a value of 0 is replaced by 32'h00000001.
- NUM_VECTORS, 256, vectors per run; legal range 0..65535.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- start  input  1  level, sampled on clk; begins a run from IDLE or DONE
- data  output  DATAWIDTH  current vector
- valid  output  1  data is valid
- ready  input  1  consumer accepts data this cycle
- done  output  1  run complete
- count  output  16  vectors accepted in the current run

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, lfsr=SEED
  - data=0, valid=0, done=0, count=0
- Reset asserted mid-run aborts the run immediately; no partial handshake completes.
- LFSR step (32-bit Galois):
  - if lfsr[0]=1: lfsr <= (lfsr>>1) ^ 32'h80200003
  - otherwise: lfsr <= lfsr>>1
- Output mapping: data = lfsr[DATAWIDTH-1:0] whenever valid=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - valid=0, done=0.
  - start=1 loads lfsr=SEED and count=0, and moves to RUN.
  - valid rises the next cycle, so latency from start is 1 clk.
- RUN:
  - valid=1.
  - Transfer occurs on a clk edge where valid=1 and ready=1. On a transfer: count increments and lfsr steps.
  - If the transfer is vector NUM_VECTORS (count becomes NUM_VECTORS), go to DONE and drop valid in the same edge.
  - ready=0: data, valid, count and lfsr hold unchanged. There is no limit on stall length.
  - start is ignored in RUN.
- DONE:
  - valid=0, done=1; count holds its final value (NUM_VECTORS).
  - start=1 clears done, reloads lfsr=SEED, clears count and moves to RUN. The restarted run repeats the identical sequence.
- NUM_VECTORS=0: start goes from IDLE straight to DONE; valid never asserts.
- start and ready both high in DONE: start wins. ready is ignored because valid=0.
- count does not wrap, because NUM_VECTORS ≤ 65535.
- data is not cleared on DONE. It holds the last LFSR low bits and has no meaning while valid=0.

Optional Feature:
- Macro: STIM_SOURCE_CORNER_EN
- Defined:
  - Each run first emits two corner vectors: all-zeros, then all-ones (DATAWIDTH bits).
  - Then the LFSR sequence starts from SEED.
  - Corner vectors count toward NUM_VECTORS.
  - The lfsr does not step on corner transfers.
  - NUM_VECTORS=1: only the zero vector is emitted.
- Undefined: pure LFSR sequence; no corner logic is synthesized.

Test Plan:
- Reset, then start pulse with SEED=1, DATAWIDTH=16, ready=1 -> valid rises 1 clk after start; data sequence 16'h0001, 16'h0003, 16'h0002; count is 1, 2, 3 after each transfer.
- NUM_VECTORS=4, ready=1 -> exactly 4 transfers; valid low and done=1 on the edge of the 4th transfer; count=4 holds.
- ready toggled 1,0,0,1 mid-run -> data, valid and count stable through both stall cycles; no vector is skipped or duplicated against a reference LFSR model.
- In DONE, start again -> done=0, count=0, and data sequence restarts at 16'h0001; start pulsed during RUN -> no effect.
- NUM_VECTORS=0 with start -> DONE the next cycle, valid never 1. rst=0 asserted mid-run asynchronously -> valid, done and count go 0 before the next clk edge.
- With STIM_SOURCE_CORNER_EN, NUM_VECTORS=4, SEED=1 -> data 16'h0000, 16'hFFFF, 16'h0001, 16'h0003, then done=1.

Source files
------------

// File: rtl/stim_source.sv
// Pseudo-random stimulus transmitter: emits NUM_VECTORS words from a 32-bit Galois LFSR over valid/ready.
// Define STIM_SOURCE_CORNER_EN to prefix every run with an all-zeros and an all-ones corner vector.
module stim_source #(
  parameter int          DATAWIDTH   = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int          NUM_VECTORS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [DATAWIDTH-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 done,
  output logic [15:0]          count
);

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [16:0] LAST      = 17'(NUM_VECTORS);
  localparam bit          EMPTY_RUN = (NUM_VECTORS == 0);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, done_q;
  logic [15:0]          count_q;
  logic                 last_xfer;

`ifdef STIM_SOURCE_CORNER_EN
  localparam logic [DATAWIDTH-1:0] FIRST_DATA = '0;
  logic [1:0] corner_q;  // 0: zero vector on the bus, 1: ones vector on the bus, 2: LFSR phase
`else
  localparam logic [DATAWIDTH-1:0] FIRST_DATA = SEED_EFF[DATAWIDTH-1:0];
`endif

  // Value of lfsr/data after a transfer of the vector currently presented.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    data_d = lfsr_d[DATAWIDTH-1:0];
`ifdef STIM_SOURCE_CORNER_EN
    if (corner_q == 2'd0) begin
      lfsr_d = lfsr_q;
      data_d = '1;
    end else if (corner_q == 2'd1) begin
      lfsr_d = lfsr_q;
      data_d = lfsr_q[DATAWIDTH-1:0];
    end
`endif
  end

  assign last_xfer = ({1'b0, count_q} + 17'd1) == LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
`ifdef STIM_SOURCE_CORNER_EN
      corner_q <= 2'd0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lfsr_q  <= SEED_EFF;
            count_q <= '0;
            data_q  <= FIRST_DATA;
`ifdef STIM_SOURCE_CORNER_EN
            corner_q <= 2'd0;
`endif
            if (EMPTY_RUN) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (ready) begin
            count_q <= count_q + 16'd1;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
`ifdef STIM_SOURCE_CORNER_EN
            if (corner_q != 2'd2) corner_q <= corner_q + 2'd1;
`endif
            if (last_xfer) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_stim_source.sv
// Bench for stim_source: three configurations checked each cycle against a transaction-level model,
// plus directed literal checks of the first vectors, done timing, stalls, restart and async reset.
module tb_stim_source;

  localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef STIM_SOURCE_CORNER_EN
  localparam bit CORNER = 1'b1;
  localparam logic [31:0] V0 = 32'h0000, V1 = 32'hFFFF, V2 = 32'h0001, V3 = 32'h0003;
`else
  localparam bit CORNER = 1'b0;
  localparam logic [31:0] V0 = 32'h0001, V1 = 32'h0003, V2 = 32'h0002, V3 = 32'h0001;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] data_w  [3];
  logic        valid_w [3];
  logic        done_w  [3];
  logic [15:0] count_w [3];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // k-th vector of a run, straight from the sequence definition.
  function automatic logic [31:0] vec_at(input int k, input logic [31:0] seed);
    logic [31:0] s;
    int steps;
    s = (seed == 32'h0) ? 32'h1 : seed;
    steps = k;
    if (CORNER) begin
      if (k == 0) return 32'h0;
      if (k == 1) return 32'hFFFF_FFFF;
      steps = k - 2;
    end
    for (int i = 0; i < steps; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    return s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int          DW = (g == 2) ? 32 : 16;
    localparam int          NV = (g == 0) ? 4 : ((g == 1) ? 0 : 40);
    localparam logic [31:0] SD = (g == 2) ? 32'h0 : 32'h1;
    localparam logic [31:0] MASK = (DW == 32) ? 32'hFFFF_FFFF : ((32'h1 << DW) - 32'h1);

    logic [DW-1:0] data_l;
    logic          valid_l, done_l;
    logic [15:0]   count_l;

    stim_source #(.DATAWIDTH(DW), .SEED(SD), .NUM_VECTORS(NV)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .data (data_l),
      .valid(valid_l),
      .ready(ready),
      .done (done_l),
      .count(count_l)
    );

    assign data_w[g]  = 32'(data_l);
    assign valid_w[g] = valid_l;
    assign done_w[g]  = done_l;
    assign count_w[g] = count_l;

    // Model: number of accepted vectors, whether a run is in flight, whether it completed.
    int idx = 0;
    bit running = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        idx     <= 0;
        running <= 1'b0;
        m_done  <= 1'b0;
      end else if (running) begin
        if (ready) begin
          idx <= idx + 1;
          if (idx + 1 == NV) begin
            running <= 1'b0;
            m_done  <= 1'b1;
          end
        end
      end else if (start) begin
        idx     <= 0;
        m_done  <= (NV == 0);
        running <= (NV != 0);
      end
    end

    always @(negedge clk) begin
      if (rst && chk_en) begin
        check($sformatf("cfg%0d valid", g), 32'(valid_l), 32'(running));
        check($sformatf("cfg%0d done", g), 32'(done_l), 32'(m_done));
        check($sformatf("cfg%0d count", g), 32'(count_l), idx);
        if (running)
          check($sformatf("cfg%0d data[%0d]", g, idx), 32'(data_l), vec_at(idx, SD) & MASK);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    pat = 32'hB3A5_96C7;

    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 32'(valid_w[0]), 32'h0);
    check("reset done", 32'(done_w[0]), 32'h0);
    check("reset count", 32'(count_w[0]), 32'h0);
    check("reset data", data_w[0], 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    step();
    check("idle valid", 32'(valid_w[0]), 32'h0);

    // First run of the 4-vector configuration, consumer always ready.
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    check("latency valid", 32'(valid_w[0]), 32'h1);
    check("vec0 data", data_w[0], V0);
    check("vec0 count", 32'(count_w[0]), 32'h0);
    check("nv0 done", 32'(done_w[1]), 32'h1);
    check("nv0 valid", 32'(valid_w[1]), 32'h0);
    step();
    check("vec1 data", data_w[0], V1);
    check("vec1 count", 32'(count_w[0]), 32'h1);
    step();
    check("vec2 data", data_w[0], V2);
    check("vec2 count", 32'(count_w[0]), 32'h2);
    step();
    check("vec3 data", data_w[0], V3);
    check("vec3 count", 32'(count_w[0]), 32'h3);
    step();
    check("end done", 32'(done_w[0]), 32'h1);
    check("end valid", 32'(valid_w[0]), 32'h0);
    check("end count", 32'(count_w[0]), 32'h4);
    step();
    step();
    check("hold count", 32'(count_w[0]), 32'h4);
    check("hold done", 32'(done_w[0]), 32'h1);

    // Restart from DONE; the 40-vector configuration is mid-run and must ignore it.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart done", 32'(done_w[0]), 32'h0);
    check("restart count", 32'(count_w[0]), 32'h0);
    check("restart data", data_w[0], V0);
    check("restart valid", 32'(valid_w[0]), 32'h1);

    // Stall pattern 1,0,0,1.
    step();
    ready = 1'b0;
    step();
    check("stall1 data", data_w[0], V1);
    check("stall1 count", 32'(count_w[0]), 32'h1);
    step();
    check("stall2 data", data_w[0], V1);
    check("stall2 valid", 32'(valid_w[0]), 32'h1);
    ready = 1'b1;
    step();
    check("resume data", data_w[0], V2);
    check("resume count", 32'(count_w[0]), 32'h2);

    // Irregular ready with periodic start pulses until the long run completes.
    for (int i = 0; i < 400 && !done_w[2]; i++) begin
      ready = pat[i % 32];
      start = (i % 7 == 3);
      step();
    end
    start = 1'b0;
    check("long run finished", 32'(done_w[2]), 32'h1);
    check("long run count", 32'(count_w[2]), 32'd40);

    // Asynchronous reset in the middle of a run.
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async valid", 32'(valid_w[2]), 32'h0);
    check("async count", 32'(count_w[2]), 32'h0);
    check("async done", 32'(done_w[1]), 32'h0);
    rst = 1'b1;

    // Full run after reset reproduces the sequence.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !done_w[2]; i++) step();
    check("rerun finished", 32'(done_w[2]), 32'h1);
    check("rerun count", 32'(count_w[2]), 32'd40);

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
